// File: rtl/qam_demap_pkg.sv
// Shared types and constants for the QAM demapper frame buffer path.
// State encoding is fixed so it can be probed and compared across builds.
package qam_demap_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RECEIVE = 2'b01,
        READY   = 2'b10,
        READOUT = 2'b11
    } qam_buf_state_t;

    localparam int QAM_DROP_CNT_W = 16;

    // A frame is held for the host in READY and READOUT.
    function automatic logic frame_held(input qam_buf_state_t state);
        return (state == READY) || (state == READOUT);
    endfunction

endpackage

// File: rtl/qam_sync_fifo.sv
// Single-clock FIFO for demapped symbols: register-array storage, wrapping
// pointers, occupancy level and a registered read port (1-cycle latency).
module qam_sync_fifo #(
    parameter int SYM_W = 4,
    parameter int DEPTH = 16
) (
    input  logic                     dclk,
    input  logic                     reset_n,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  logic [SYM_W-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [SYM_W-1:0]         o_rdata,
    output logic                     o_rvalid,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [SYM_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic [SYM_W-1:0] r_rdata;
    logic             r_rvalid;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_level == FULL_LVL);
    assign o_empty = (r_level == '0);
    assign w_push  = i_push && !o_full && !i_clear;
    assign w_pop   = i_pop && !o_empty && !i_clear;

    // NOTE: storage has no reset; pointers and level define what is valid,
    // so a reset-free array maps onto plain registers or distributed RAM.
    always_ff @(posedge dclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // NOTE: all clocked state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge dclk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Read data holds its last value between pops; only the strobe pulses.
    always_ff @(posedge dclk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_pop;
            if (w_pop) begin
                r_rdata <= r_mem[r_rd_ptr];
            end
        end
    end

    assign o_rdata  = r_rdata;
    assign o_rvalid = r_rvalid;
    assign o_level  = r_level;

endmodule

// File: rtl/qam_frame_buffer_ctrl.sv
// Frame buffer controller: buffers one frame of demapped symbols and hands it
// to the host. Optional drop counter is built when QAM_DROP_CNT_EN is defined.
module qam_frame_buffer_ctrl
    import qam_demap_pkg::*;
#(
    parameter int SYM_W     = 4,
    parameter int DEPTH     = 16,
    parameter int FRAME_LEN = 16
) (
    input  logic                      dclk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic                      clear,
    input  logic                      sym_valid,
    input  logic [SYM_W-1:0]          sym_data,
    input  logic                      read_enable,
    output logic                      rd_valid,
    output logic [SYM_W-1:0]          rd_data,
    output logic                      available,
    output logic                      complete,
    output logic [$clog2(DEPTH):0]    level
`ifdef QAM_DROP_CNT_EN
    ,
    output logic [QAM_DROP_CNT_W-1:0] drop_cnt
`endif
);

    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam logic [LVL_W-1:0] FRAME_LVL = LVL_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_POP  = CNT_W'(FRAME_LEN - 1);

    qam_buf_state_t   r_state;
    qam_buf_state_t   w_state_next;
    logic [CNT_W-1:0] r_rd_cnt;
    logic             r_available;
    logic             r_complete;
    logic             w_available_next;
    logic             w_complete_next;
    logic             w_live;
    logic             w_push;
    logic             w_pop;
    logic             w_last_pop;
    logic             w_full;
    logic             w_empty;
    logic [LVL_W-1:0] w_level;
    logic [LVL_W-1:0] w_level_after;

    // Writes are accepted while collecting a frame and while draining one.
    assign w_live        = enable && !clear;
    assign w_push        = w_live && sym_valid && !w_full &&
                           ((r_state == RECEIVE) || (r_state == READOUT));
    assign w_pop         = w_live && read_enable && !w_empty && (r_state == READOUT);
    assign w_last_pop    = w_pop && (r_rd_cnt == LAST_POP);
    assign w_level_after = w_level + LVL_W'(w_push);

    qam_sync_fifo #(
        .SYM_W (SYM_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .dclk     (dclk),
        .reset_n  (reset_n),
        .i_clear  (clear),
        .i_push   (w_push),
        .i_wdata  (sym_data),
        .i_pop    (w_pop),
        .o_rdata  (rd_data),
        .o_rvalid (rd_valid),
        .o_level  (w_level),
        .o_full   (w_full),
        .o_empty  (w_empty)
    );

    always_ff @(posedge dclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every combinational output gets a default before any branch,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        if (!w_live) begin
            w_state_next = IDLE;
        end else begin
            unique case (r_state)
                IDLE:    w_state_next = RECEIVE;
                RECEIVE: if (w_level_after >= FRAME_LVL) w_state_next = READY;
                READY:   if (read_enable)               w_state_next = READOUT;
                READOUT: if (w_last_pop)                w_state_next = RECEIVE;
            endcase
        end
    end

    always_comb begin
        w_available_next = frame_held(r_state);
        w_complete_next  = !frame_held(r_state);
    end

    // Flags are registered from the state, so they trail a transition by a cycle.
    always_ff @(posedge dclk or negedge reset_n) begin
        if (!reset_n) begin
            r_available <= 1'b0;
            r_complete  <= 1'b1;
        end else begin
            r_available <= w_available_next;
            r_complete  <= w_complete_next;
        end
    end

    always_ff @(posedge dclk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_cnt <= '0;
        end else if (clear || w_last_pop) begin
            r_rd_cnt <= '0;
        end else if (w_pop) begin
            r_rd_cnt <= r_rd_cnt + CNT_W'(1);
        end
    end

`ifdef QAM_DROP_CNT_EN
    logic [QAM_DROP_CNT_W-1:0] r_drop_cnt;
    logic                      w_drop;

    // Any offered symbol that does not reach the FIFO counts as dropped.
    assign w_drop = sym_valid && !w_push;

    always_ff @(posedge dclk or negedge reset_n) begin
        if (!reset_n) begin
            r_drop_cnt <= '0;
        end else if (clear) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + QAM_DROP_CNT_W'(1);
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

    assign available = r_available;
    assign complete  = r_complete;
    assign level     = w_level;

endmodule
